// File: rtl/apb_uart_tx_fifo.sv
// APB3 UART transmitter (16550 register subset) with a parametrised TX FIFO.
// Characters written to THR are queued and serialised on txd_o at {DLM,DLL} clocks per bit.
module apb_uart_tx_fifo #(
    parameter int TX_FIFO_DEPTH  = 16,
    parameter int APB_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      txd_o,
    output logic                      irq_o
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    lcr, dll, dlm, scr, wd, rdata;
    logic          etbei, fifo_en;
    logic [7:0]    mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    state_e        state, state_n;
    logic [15:0]   baud_cnt, baud_cnt_n, div_m1;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          stop2, stop2_n, txd_q, txd_n;
    logic [2:0]    idx;
    logic          access, err, dlab, wr_en, thr_wr, fcr_wr, flush, full, push, pop, thre, temt;
    logic          unused_bits;

    assign idx       = paddr_i[4:2];
    assign wd        = pwdata_i[7:0];
    assign access    = psel_i & penable_i;
    assign err       = (idx == 3'd4) | (idx == 3'd6);
    assign dlab      = lcr[7];
    assign wr_en     = access & pwrite_i & ~err;
    assign thr_wr    = wr_en & (idx == 3'd0) & ~dlab;
    assign fcr_wr    = wr_en & (idx == 3'd2);
    // Toggling the enable also discards queued characters.
    assign flush     = fcr_wr & (wd[2] | (wd[0] != fifo_en));
    assign full      = fifo_en ? (count == (AW+1)'(TX_FIFO_DEPTH)) : (count != '0);
    assign push      = thr_wr & ~flush & (~full | pop);
    assign thre      = (count == '0);
    assign temt      = thre & (state == IDLE);
    assign div_m1    = ({dlm, dll} == 16'd0) ? 16'd0 : {dlm, dll} - 16'd1;
    assign pready_o  = 1'b1;
    assign pslverr_o = access & err;
    assign txd_o     = txd_q & ~lcr[6];
    assign prdata_o  = {24'h0, rdata};
    assign unused_bits = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0], pwdata_i[31:8]};

    always_comb begin
        rdata = 8'h00;
        if (access && !pwrite_i) begin
            case (idx)
                3'd0:    rdata = dlab ? dll : 8'h00;
                3'd1:    rdata = dlab ? dlm : {6'b0, etbei, 1'b0};
                3'd2:    rdata = {fifo_en ? 2'b11 : 2'b00, 4'b0, irq_o ? 2'b10 : 2'b01};
                3'd3:    rdata = lcr;
                3'd5:    rdata = {1'b0, temt, thre, 5'b0};
                3'd7:    rdata = scr;
                default: rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lcr     <= 8'h03;
            dll     <= 8'h01;
            dlm     <= 8'h00;
            scr     <= 8'h00;
            etbei   <= 1'b0;
            fifo_en <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (idx)
                    3'd0:    if (dlab) dll <= wd;
                    3'd1:    if (dlab) dlm <= wd; else etbei <= wd[1];
                    3'd2:    fifo_en <= wd[0];
                    3'd3:    lcr <= wd;
                    3'd7:    scr <= wd;
                    default: ;
                endcase
            end
            irq_o <= etbei & thre;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count separates full from empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wd;
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop2_n    = stop2;
        txd_n      = 1'b1;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0 && !flush) begin
                    pop        = 1'b1;
                    shreg_n    = mem[rptr];
                    bit_cnt_n  = {1'b1, lcr[1:0]};  // data bits minus one
                    stop2_n    = lcr[2];
                    baud_cnt_n = div_m1;
                    state_n    = START;
                    txd_n      = 1'b0;
                end
            end
            START: begin
                txd_n = 1'b0;
                if (baud_cnt == 16'd0) begin
                    state_n    = DATA;
                    baud_cnt_n = div_m1;
                    txd_n      = shreg[0];
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                txd_n = shreg[0];
                if (baud_cnt == 16'd0) begin
                    baud_cnt_n = div_m1;
                    if (bit_cnt == 3'd0) begin
                        state_n   = STOP;
                        bit_cnt_n = {2'b0, stop2};
                        txd_n     = 1'b1;
                    end else begin
                        shreg_n   = shreg >> 1;
                        bit_cnt_n = bit_cnt - 3'd1;
                        txd_n     = shreg[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_n = div_m1;
                    if (bit_cnt == 3'd0) state_n = IDLE;
                    else bit_cnt_n = bit_cnt - 3'd1;
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            shreg    <= 8'h00;
            bit_cnt  <= 3'd0;
            stop2    <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop2    <= stop2_n;
            txd_q    <= txd_n;
        end
    end

endmodule

// File: tb/tb_apb_uart_tx_fifo.sv
// Bench for apb_uart_tx_fifo: APB stimulus pushes expected characters into a queue,
// and an independent UART receiver on txd_o pops and compares each decoded frame.
module tb_apb_uart_tx_fifo;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'h0, pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr, txd, irq;

    apb_uart_tx_fifo #(.TX_FIFO_DEPTH(16), .APB_ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .txd_o(txd), .irq_o(irq)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [7:0] d; int nb; int ns; int dv;} fr_t;
    fr_t exp_q[$];
    int n_vec = 0, n_err = 0;
    int div_cur = 1, nb_cur = 8, ns_cur = 1;
    int aborts = 0, last_fall = 0;
    bit rx_busy = 0;
    logic        last_err;
    logic [31:0] rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic apb_wr(input int idx, input logic [7:0] d);
        paddr = $urandom(); paddr[4:2] = idx[2:0];
        pwdata = $urandom(); pwdata[7:0] = d;
        psel = 1; penable = 0; pwrite = 1;
        @(negedge clk); penable = 1; #1 last_err = pslverr;
        @(negedge clk); psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_rd(input int idx, output logic [31:0] data);
        paddr = $urandom(); paddr[4:2] = idx[2:0];
        psel = 1; penable = 0; pwrite = 0;
        @(negedge clk); penable = 1; #1 data = prdata; last_err = pslverr;
        @(negedge clk); psel = 0; penable = 0;
    endtask

    task automatic send(input logic [7:0] d);
        fr_t f;
        apb_wr(0, d);
        f.d = d & 8'((1 << nb_cur) - 1); f.nb = nb_cur; f.ns = ns_cur; f.dv = div_cur;
        exp_q.push_back(f);
    endtask

    task automatic set_fmt(input logic [7:0] l, input int dv);
        apb_wr(3, 8'h80 | l); apb_wr(0, dv[7:0]); apb_wr(1, dv[15:8]); apb_wr(3, l);
        div_cur = (dv == 0) ? 1 : dv; nb_cur = 5 + int'(l[1:0]); ns_cur = l[2] ? 2 : 1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!rx_busy && n < budget) begin @(negedge clk); n++; end
        if (!rx_busy) begin n_vec++; n_err++; $display("FAIL frame_start_timeout: no start bit after %0d cycles", budget); end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rx_busy) && n < budget) begin @(negedge clk); n++; end
        if (n >= budget) begin n_vec++; n_err++; $display("FAIL idle_timeout: %0d frames still pending", exp_q.size()); end
        repeat (div_cur * 3 + 3) @(negedge clk);
    endtask

    // UART receiver: samples each bit at its first cycle, relative to the falling start edge.
    initial begin : rx
        logic prev, stop_ok;
        logic [7:0] got;
        int c, ab;
        fr_t fr;
        prev = 1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !txd) begin
                c = cyc; ab = aborts; last_fall = c; rx_busy = 1;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", c);
                    fr.d = 0; fr.nb = nb_cur; fr.ns = ns_cur; fr.dv = div_cur;
                end else fr = exp_q.pop_front();
                got = 0; stop_ok = 1;
                for (int j = 1; j <= fr.nb + fr.ns; j++) begin
                    while (cyc < c + fr.dv * j) @(negedge clk);
                    if (j <= fr.nb) got[j-1] = txd; else stop_ok &= txd;
                end
                if (ab == aborts) begin
                    chk("rx_data", {24'h0, got}, {24'h0, fr.d});
                    chk("rx_stop", {31'h0, stop_ok}, 32'h1);
                end
                rx_busy = 0; prev = 1;
            end else prev = txd;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] d, l;
        int dv, k, f1;
        // reset state
        #12;
        chk("rst_txd", {31'h0, txd}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_pready", {31'h0, pready}, 32'h1);
        chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        @(negedge clk); rst_n = 1; @(negedge clk);
        apb_rd(5, rd); chk("rst_lsr", rd, 32'h60);
        apb_rd(3, rd); chk("rst_lcr", rd, 32'h03);
        apb_rd(2, rd); chk("rst_iir", rd, 32'h01);
        apb_rd(1, rd); chk("rst_ier", rd, 32'h00);
        apb_rd(0, rd); chk("thr_read_zero", rd, 32'h00);

        // 8N1 at divisor 4
        apb_wr(3, 8'h83); apb_wr(0, 8'd4); apb_wr(1, 8'd0);
        apb_rd(0, rd); chk("dll_readback", rd, 32'h04);
        apb_rd(1, rd); chk("dlm_readback", rd, 32'h00);
        apb_wr(3, 8'h03); div_cur = 4; nb_cur = 8; ns_cur = 1;
        send(8'hA5);
        wait_idle(200);
        apb_rd(5, rd); chk("temt_after_a5", rd, 32'h60);

        // scratch and error slots
        d = 8'($urandom());
        apb_wr(7, d); apb_rd(7, rd); chk("scr_rw", rd, {24'h0, d});
        apb_rd(4, rd); chk("mcr_pslverr", {31'h0, last_err}, 32'h1); chk("mcr_prdata", rd, 32'h0);
        apb_wr(6, 8'hFF); chk("msr_wr_pslverr", {31'h0, last_err}, 32'h1);
        apb_rd(5, rd); chk("lsr_no_err", {31'h0, last_err}, 32'h0);

        // random formats/divisors with FIFO enabled
        apb_wr(2, 8'h01);
        for (int r = 0; r < 6; r++) begin
            dv = $urandom_range(0, 4); l = 8'($urandom_range(0, 7));
            set_fmt(l, dv);
            k = $urandom_range(1, 16);
            for (int i = 0; i < k; i++) send(8'($urandom()));
            wait_idle(2000);
            apb_rd(5, rd); chk("lsr_after_round", rd, 32'h60);
        end

        // overflow: shifter busy plus 16 queued, rest dropped; write coinciding with pop accepted
        set_fmt(8'h03, 8);
        send(8'h00);
        wait_busy(20); f1 = last_fall;
        for (int i = 1; i < 20; i++) begin
            if (i <= 16) send(8'(i)); else apb_wr(0, 8'(i));
        end
        apb_rd(5, rd); chk("lsr_full", rd, 32'h00);
        wait_cyc(f1 + 77); apb_wr(0, 8'h20);
        wait_cyc(f1 + 79); send(8'h21);
        wait_idle(3000);
        apb_rd(5, rd); chk("lsr_drained", rd, 32'h60);

        // THR-empty interrupt
        set_fmt(8'h03, 2);
        apb_wr(1, 8'h02);
        chk("irq_lag", {31'h0, irq}, 32'h0);
        @(negedge clk); chk("irq_set", {31'h0, irq}, 32'h1);
        apb_rd(2, rd); chk("iir_irq", rd, 32'hC2);
        send(8'h77);
        chk("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk); chk("irq_drop", {31'h0, irq}, 32'h0);
        @(negedge clk); chk("irq_reassert", {31'h0, irq}, 32'h1);
        apb_wr(1, 8'h00);
        wait_idle(200);

        // 5 data bits, 2 stop bits; upper data bits ignored
        set_fmt(8'h04, 3);
        send(8'hFF); send(8'h1F); send(8'hE0);
        wait_idle(500);

        // LCR change mid-frame applies to the next character only
        set_fmt(8'h03, 3);
        send(8'h5A);
        wait_busy(20);
        apb_wr(3, 8'h00); nb_cur = 5; ns_cur = 1;
        send(8'h13);
        wait_idle(500);

        // flush while shifting: current frame completes, queued ones vanish
        set_fmt(8'h03, 4);
        send(8'h11);
        wait_busy(20);
        apb_wr(0, 8'h22); apb_wr(0, 8'h33); apb_wr(2, 8'h07);
        apb_rd(5, rd); chk("lsr_after_flush", rd, 32'h20);
        wait_idle(500);

        // reset mid-DATA
        send(8'hC3); send(8'h3C);
        wait_busy(20);
        wait_cyc(last_fall + 4 * 3);
        chk("pre_reset_txd", {31'h0, txd}, 32'h0);
        rst_n = 0; aborts++;
        #1 chk("async_reset_txd", {31'h0, txd}, 32'h1);
        exp_q.delete(); div_cur = 1; nb_cur = 8; ns_cur = 1;
        @(negedge clk); rst_n = 1;
        wait_idle(200);
        apb_rd(5, rd); chk("post_reset_lsr", rd, 32'h60);
        apb_rd(3, rd); chk("post_reset_lcr", rd, 32'h03);
        apb_rd(2, rd); chk("post_reset_iir", rd, 32'h01);
        repeat (60) @(negedge clk);
        chk("post_reset_idle_txd", {31'h0, txd}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
